// File: rtl/dtree_pkg.sv
// Shared types and widths for the sequential decision-tree evaluator.
package dtree_pkg;

    localparam int DT_N_FEAT    = 16;
    localparam int DT_FEAT_W    = 8;
    localparam int DT_CLASS_W   = 4;
    localparam int DT_NODE_AW   = 6;
    localparam int DT_MAX_DEPTH = 15;
    localparam int DT_FIDX_W    = $clog2(DT_N_FEAT);

    typedef struct packed {
        logic                  is_leaf;
        logic [DT_FIDX_W-1:0]  feat_idx;
        logic [DT_FEAT_W-1:0]  thresh;
        logic [DT_NODE_AW-1:0] left;
        logic [DT_NODE_AW-1:0] right;
        logic [DT_CLASS_W-1:0] cls;
    } node_t;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dtree_node_rom.sv
// Combinational node table. This copy holds the small verification tree; the
// root's left child is a parameter so a self-looping root can be built.
module dtree_node_rom
    import dtree_pkg::*;
#(
    parameter logic [DT_NODE_AW-1:0] ROOT_LEFT = DT_NODE_AW'(1)
) (
    input  logic [DT_NODE_AW-1:0] i_addr,
    output node_t                 o_node
);

    always_comb begin
        // Any address not listed below reads as a class-0 leaf.
        o_node         = '0;
        o_node.is_leaf = 1'b1;
        case (i_addr)
            DT_NODE_AW'(0): begin
                o_node.is_leaf  = 1'b0;
                o_node.feat_idx = DT_FIDX_W'(15);
                o_node.thresh   = DT_FEAT_W'(127);
                o_node.left     = ROOT_LEFT;
                o_node.right    = DT_NODE_AW'(2);
            end
            DT_NODE_AW'(1): o_node.cls = DT_CLASS_W'(3);
            DT_NODE_AW'(2): o_node.cls = DT_CLASS_W'(7);
            default: ;
        endcase
    end

endmodule

// File: rtl/dtree_seq_eval.sv
// Decision-tree classifier: loads a feature vector serially, then walks the node
// table one node per cycle through a single shared comparator.
module dtree_seq_eval
    import dtree_pkg::*;
#(
    parameter int N_FEAT    = DT_N_FEAT,
    parameter int FEAT_W    = DT_FEAT_W,
    parameter int CLASS_W   = DT_CLASS_W,
    parameter int NODE_AW   = DT_NODE_AW,
    parameter int MAX_DEPTH = DT_MAX_DEPTH,
    parameter logic [DT_NODE_AW-1:0] ROOT_LEFT = DT_NODE_AW'(1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FEAT_W-1:0]  in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLASS_W-1:0] out_class,
    output logic               out_err,
    output logic               busy
);

    localparam int CNT_W   = $clog2(N_FEAT + 1);
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
    localparam int FIDX_W  = $clog2(N_FEAT);
    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(N_FEAT);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(N_FEAT - 1);
    localparam logic [DEPTH_W-1:0] DEPTH_LIM = DEPTH_W'(MAX_DEPTH - 1);

    state_t               r_state, w_state_nxt;
    logic [FEAT_W-1:0]    r_feat [N_FEAT];
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic                 r_len_err, w_len_err_nxt;
    logic [NODE_AW-1:0]   r_node, w_node_nxt;
    logic [DEPTH_W-1:0]   r_depth, w_depth_nxt;
    logic [CLASS_W-1:0]   r_class, w_class_nxt;
    logic                 r_err, w_err_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 w_feat_we;
    logic                 w_beat;
    logic                 w_go_left;
    node_t                w_node;

    dtree_node_rom #(
        .ROOT_LEFT (ROOT_LEFT)
    ) u_rom (
        .i_addr (r_node),
        .o_node (w_node)
    );

    // in_ready is gated by rst so nothing is offered while reset is held.
    assign in_ready  = (r_state == LOAD) && !rst;
    assign w_beat    = in_valid && in_ready;
    assign w_go_left = (r_feat[w_node.feat_idx] <= w_node.thresh);
    assign out_valid = r_valid;
    assign out_class = r_class;
    assign out_err   = r_err;
    assign busy      = (r_state != LOAD);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_len_err_nxt = r_len_err;
        w_node_nxt    = r_node;
        w_depth_nxt   = r_depth;
        w_class_nxt   = r_class;
        w_err_nxt     = r_err;
        w_valid_nxt   = r_valid;
        w_feat_we     = 1'b0;
        unique case (r_state)
            LOAD: begin
                if (w_beat) begin
                    if (r_cnt < CNT_FULL) begin
                        w_feat_we = 1'b1;
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end else begin
                        w_len_err_nxt = 1'b1;
                    end
                    if (in_last) begin
                        if ((r_cnt == CNT_LAST) && !r_len_err) begin
                            w_state_nxt = WALK;
                            w_node_nxt  = '0;
                            w_depth_nxt = '0;
                        end else begin
                            w_state_nxt = DONE;
                            w_err_nxt   = 1'b1;
                            w_class_nxt = '0;
                            w_valid_nxt = 1'b1;
                        end
                    end
                end
            end
            WALK: begin
                if (w_node.is_leaf) begin
                    w_state_nxt = DONE;
                    w_class_nxt = w_node.cls;
                    w_err_nxt   = 1'b0;
                    w_valid_nxt = 1'b1;
                end else if (r_depth == DEPTH_LIM) begin
                    // This internal visit is the MAX_DEPTH-th: treat the table as looping.
                    w_state_nxt = DONE;
                    w_class_nxt = '0;
                    w_err_nxt   = 1'b1;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_node_nxt  = w_go_left ? w_node.left : w_node.right;
                    w_depth_nxt = r_depth + DEPTH_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt   = LOAD;
                    w_valid_nxt   = 1'b0;
                    w_cnt_nxt     = '0;
                    w_len_err_nxt = 1'b0;
                end
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= LOAD;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_len_err <= 1'b0;
            r_node    <= '0;
            r_depth   <= '0;
            r_class   <= '0;
            r_err     <= 1'b0;
            r_valid   <= 1'b0;
            for (int i = 0; i < N_FEAT; i++) r_feat[i] <= '0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_len_err <= w_len_err_nxt;
            r_node    <= w_node_nxt;
            r_depth   <= w_depth_nxt;
            r_class   <= w_class_nxt;
            r_err     <= w_err_nxt;
            r_valid   <= w_valid_nxt;
            if (w_feat_we) r_feat[r_cnt[FIDX_W-1:0]] <= in_data;
        end
    end

endmodule

// File: tb/tb_dtree_seq_eval.sv
// Directed bench for dtree_seq_eval: a normal test tree plus a second instance
// whose root loops to itself to exercise the depth abort.
module tb_dtree_seq_eval;

    logic       clk;
    logic       rst;
    logic       in_valid, in_last, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid, out_err, busy;
    logic [3:0] out_class;

    logic       c_in_valid, c_in_last, c_out_ready;
    logic [7:0] c_in_data;
    logic       c_in_ready, c_out_valid, c_out_err, c_busy;
    logic [3:0] c_out_class;

    int total = 0;
    int bad   = 0;

    dtree_seq_eval dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_err   (out_err),
        .busy      (busy)
    );

    dtree_seq_eval #(.ROOT_LEFT(6'd0)) dut_cyc (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (c_in_valid),
        .in_ready  (c_in_ready),
        .in_data   (c_in_data),
        .in_last   (c_in_last),
        .out_valid (c_out_valid),
        .out_ready (c_out_ready),
        .out_class (c_out_class),
        .out_err   (c_out_err),
        .busy      (c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Beat i carries feature i; only feature 15 matters to the test tree.
    task automatic send_vec(input int nbeats, input logic [7:0] f15);
        for (int i = 0; i < nbeats; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 15) ? f15 : 8'd0;
            in_last  = (i == nbeats - 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'd0;
    endtask

    // lat = cycle index (beat cycle = 0) in which out_valid is first seen.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_class !== 4'd0) begin bad++; $display("FAIL reset_out_class got=%0d want=0", out_class); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err got=%b want=0", out_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_classify;
        logic [7:0] f15s [4] = '{8'd127, 8'd128, 8'd255, 8'd0};
        logic [3:0] want [4] = '{4'd3, 4'd7, 4'd7, 4'd3};
        int lat;
        for (int v = 0; v < 4; v++) begin
            send_vec(16, f15s[v]);
            wait_out(lat);
            total++; if (lat != 3) begin bad++; $display("FAIL classify%0d_latency got=%0d want=3", v, lat); end
            total++; if (out_class !== want[v]) begin bad++; $display("FAIL classify%0d_class got=%0d want=%0d", v, out_class, want[v]); end
            total++; if (out_err !== 1'b0) begin bad++; $display("FAIL classify%0d_err got=%b want=0", v, out_err); end
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL classify%0d_handshake valid=%b ready=%b want 0/1", v, out_valid, in_ready); end
        end
    endtask

    task automatic test_length_err;
        int nb [2] = '{10, 18};
        int lat;
        for (int v = 0; v < 2; v++) begin
            send_vec(nb[v], 8'd200);
            wait_out(lat);
            total++; if (lat != 1) begin bad++; $display("FAIL len%0d_latency got=%0d want=1", nb[v], lat); end
            total++; if (out_err !== 1'b1) begin bad++; $display("FAIL len%0d_err got=%b want=1", nb[v], out_err); end
            total++; if (out_class !== 4'd0) begin bad++; $display("FAIL len%0d_class got=%0d want=0", nb[v], out_class); end
            @(posedge clk); #1;
        end
        // A correct vector right after an error must not inherit the error flag.
        send_vec(16, 8'd128);
        wait_out(lat);
        total++; if (out_class !== 4'd7 || out_err !== 1'b0) begin bad++; $display("FAIL len_recover class=%0d err=%b want 7/0", out_class, out_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int lat;
        out_ready = 1'b0;
        send_vec(16, 8'd200);
        wait_out(lat);
        total++; if (out_class !== 4'd7 || out_err !== 1'b0) begin bad++; $display("FAIL bp_result class=%0d err=%b want 7/0", out_class, out_err); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || out_class !== 4'd7 || out_err !== 1'b0 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d valid=%b class=%0d err=%b ready=%b want 1/7/0/0", c, out_valid, out_class, out_err, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_release valid=%b ready=%b want 0/1", out_valid, in_ready); end
        send_vec(16, 8'd5);
        wait_out(lat);
        total++; if (lat != 3 || out_class !== 4'd3 || out_err !== 1'b0) begin bad++; $display("FAIL b2b_vector lat=%0d class=%0d err=%b want 3/3/0", lat, out_class, out_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_depth_overrun;
        int lat;
        for (int i = 0; i < 16; i++) begin
            c_in_valid = 1'b1;
            c_in_data  = 8'd0;
            c_in_last  = (i == 15);
            @(posedge clk); #1;
        end
        c_in_valid = 1'b0;
        c_in_last  = 1'b0;
        lat = 1;
        while (!c_out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        // 15 internal visits in WALK, result in the following cycle.
        total++; if (lat != 16) begin bad++; $display("FAIL depth_latency got=%0d want=16", lat); end
        total++; if (c_out_err !== 1'b1) begin bad++; $display("FAIL depth_err got=%b want=1", c_out_err); end
        total++; if (c_out_class !== 4'd0) begin bad++; $display("FAIL depth_class got=%0d want=0", c_out_class); end
        @(posedge clk); #1;
        total++; if (c_in_ready !== 1'b1) begin bad++; $display("FAIL depth_return got=%b want=1", c_in_ready); end
    endtask

    task automatic test_reset_mid_walk;
        int lat;
        send_vec(16, 8'd128);
        total++; if (busy !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL midwalk_busy busy=%b valid=%b want 1/0", busy, out_valid); end
        #2 rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_class !== 4'd0 || out_err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL midwalk_reset valid=%b class=%0d err=%b busy=%b ready=%b want all 0", out_valid, out_class, out_err, busy, in_ready);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL postreset_ready got=%b want=1", in_ready); end
        @(posedge clk); #1;
        send_vec(16, 8'd255);
        wait_out(lat);
        total++; if (lat != 3 || out_class !== 4'd7 || out_err !== 1'b0) begin bad++; $display("FAIL postreset_vector lat=%0d class=%0d err=%b want 3/7/0", lat, out_class, out_err); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_data     = 8'd0;
        out_ready   = 1'b1;
        c_in_valid  = 1'b0;
        c_in_last   = 1'b0;
        c_in_data   = 8'd0;
        c_out_ready = 1'b1;
        test_reset();
        test_classify();
        test_length_err();
        test_back_to_back();
        test_depth_overrun();
        test_reset_mid_walk();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
